hazard_stall_controller: RTL

//  Sequencing controller for the 5-stage RISC-V pipeline driven by the decoded control unit.

---
 rtl/hazard_stall_controller.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//   Sequencing controller for the 5-stage RISC-V pipeline. It resolves
//   EX-stage operand forwarding, load-use stalls, taken-branch flushes and
//   multi-cycle data-memory waits, and drives the per-stage stall/flush
//   enables of the pipeline registers.
//
// Parameters
//   REG_ADDR_W   register-file address width
//   MEM_TIMEOUT  maximum cycles spent in MEM_WAIT before the access is aborted (>=2)
//   CNT_W        width of the stall-cycle performance counter
//
// Ports
//   clk                      core clock, rising edge
//   rst                      asynchronous reset, active-low
//   Rs1D, Rs2D               source registers of the Decode instruction
//   Rs1E, Rs2E               source registers of the Execute instruction
//   RdE, RdM, RdW            destination registers in Execute/Memory/Writeback
//   RegWriteM, RegWriteW     Memory/Writeback instruction writes a register
//   ResultSrcE               Execute instruction is a load
//   PCSrcE                   branch/jump taken, resolved in Execute
//   MemReqM                  Memory instruction accesses data memory
//   MemReadyM                data memory completes the access this cycle
//   ForwardAE, ForwardBE     operand select: 00 regfile, 01 W result, 10 M ALU result
//   StallF/D/E/M             hold the corresponding pipeline register / PC
//   FlushD/E/W               clear the corresponding pipeline register to a bubble
//   MemErr                   sticky memory-timeout flag
//   StallCount               saturating count of cycles with StallF asserted
module hazard_stall_controller #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  ResultSrcE,
    input  logic                  PCSrcE,
    input  logic                  MemReqM,
    input  logic                  MemReadyM,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic                  MemErr,
    output logic [CNT_W-1:0]      StallCount
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic              set_err;

    logic              timeout;
    logic              mem_stall;
    logic              load_use;

    // ------------------------------------------------------------------
    // Forwarding: M has priority over W; x0 is never forwarded.
    // ------------------------------------------------------------------
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
            ForwardAE = 2'b01;
        end
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
            ForwardBE = 2'b01;
        end
    end

    // ------------------------------------------------------------------
    // Hazard conditions
    // ------------------------------------------------------------------
    assign timeout   = (state == MEM_WAIT) && (wait_cnt == WAIT_LAST);
    assign load_use  = ResultSrcE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    // The stall is raised combinationally in the RUN cycle that first sees
    // the unanswered request, before the FSM has moved to MEM_WAIT.
    assign mem_stall = ((state == RUN) && MemReqM && !MemReadyM) ||
                       ((state == MEM_WAIT) && !MemReadyM && !timeout);

    // ------------------------------------------------------------------
    // Stall/flush outputs, priority: memory stall > taken branch > load-use.
    // Everything is forced low while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            if (mem_stall) begin
                // E is frozen, so a taken branch there is simply held until release.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                // The Decode instruction is killed, so no load-use stall is needed.
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory-wait FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        set_err       = 1'b0;
        case (state)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = '0;
                end
            end
            MEM_WAIT: begin
                // Ready wins over timeout: a completion on the last allowed
                // cycle is a normal completion.
                if (MemReadyM) begin
                    state_next = RUN;
                end else if (timeout) begin
                    state_next = RUN;
                    set_err    = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flag and saturating stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MemErr <= 1'b0;
        end else if (set_err) begin
            MemErr <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCount <= '0;
        end else if (StallF && (StallCount != '1)) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule
